// File: rtl/all_gates.sv
// Registered seven-gate evaluator with a saturating sample counter and bit-0 input-pair coverage.
// Optional macro ALL_GATES_PARITY_EN adds parity_out, the XOR-reduction of all seven results.
module all_gates #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] not_out,
    output logic [WIDTH-1:0] nand_out,
    output logic [WIDTH-1:0] nor_out,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] xnor_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [3:0]       combo_seen
`ifdef ALL_GATES_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    // Even-parity helper over the concatenated gate results.
    function automatic logic parity_fn(input logic [7*WIDTH-1:0] vec);
        return ^vec;
    endfunction

    logic [WIDTH-1:0] and_r, or_r, not_r, nand_r, nor_r, xor_r, xnor_r;
    logic             valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       combo_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [3:0]       combo_next_s;

    // Next-state for counter and coverage; clr takes priority over a sample.
    always_comb begin
        cnt_next_s   = cnt_r;
        combo_next_s = combo_r;
        if (clr) begin
            cnt_next_s   = {CNT_W{1'b0}};
            combo_next_s = 4'b0000;
        end else if (in_valid) begin
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_next_s = cnt_r;
            end
            combo_next_s = combo_r | (4'b0001 << {a[0], b[0]});
        end else begin
            cnt_next_s   = cnt_r;
            combo_next_s = combo_r;
        end
    end

    // Gate result registers; they hold whenever no sample is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_r  <= {WIDTH{1'b0}};
            or_r   <= {WIDTH{1'b0}};
            not_r  <= {WIDTH{1'b0}};
            nand_r <= {WIDTH{1'b0}};
            nor_r  <= {WIDTH{1'b0}};
            xor_r  <= {WIDTH{1'b0}};
            xnor_r <= {WIDTH{1'b0}};
        end else if (in_valid) begin
            and_r  <= a & b;
            or_r   <= a | b;
            not_r  <= ~a;
            nand_r <= ~(a & b);
            nor_r  <= ~(a | b);
            xor_r  <= a ^ b;
            xnor_r <= ~(a ^ b);
        end
    end

    // Valid flag, counter and coverage state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            combo_r <= 4'b0000;
        end else begin
            valid_r <= in_valid;
            cnt_r   <= cnt_next_s;
            combo_r <= combo_next_s;
        end
    end

`ifdef ALL_GATES_PARITY_EN
    logic parity_r;

    // Parity computed from the same operands so it lands with the gate results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else if (in_valid) begin
            parity_r <= parity_fn({a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)});
        end
    end

    assign parity_out = parity_r;
`endif

    assign and_out    = and_r;
    assign or_out     = or_r;
    assign not_out    = not_r;
    assign nand_out   = nand_r;
    assign nor_out    = nor_r;
    assign xor_out    = xor_r;
    assign xnor_out   = xnor_r;
    assign out_valid  = valid_r;
    assign sample_cnt = cnt_r;
    assign combo_seen = combo_r;

endmodule

// File: tb/tb_all_gates.sv
// Directed self-checking bench for all_gates: gate truth table, hold, clear, reset and saturation.
module tb_all_gates;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, in_valid, clr;
    logic and_o, or_o, not_o, nand_o, nor_o, xor_o, xnor_o, out_valid;
    logic [15:0] sample_cnt;
    logic [3:0]  combo_seen;

    logic s_valid;
    logic s_and, s_or, s_not, s_nand, s_nor, s_xor, s_xnor, s_ov;
    logic [1:0] s_cnt;
    logic [3:0] s_combo;

`ifdef ALL_GATES_PARITY_EN
    logic par_o, s_par, p_par, p_ov;
    logic [3:0] pa, pb;
    logic p_valid;
    logic [3:0] p_and, p_or, p_not, p_nand, p_nor, p_xor, p_xnor;
    logic [15:0] p_cnt;
    logic [3:0] p_combo;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    all_gates #(.WIDTH(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .clr(clr),
        .and_out(and_o), .or_out(or_o), .not_out(not_o), .nand_out(nand_o),
        .nor_out(nor_o), .xor_out(xor_o), .xnor_out(xnor_o), .out_valid(out_valid),
        .sample_cnt(sample_cnt), .combo_seen(combo_seen)
`ifdef ALL_GATES_PARITY_EN
        , .parity_out(par_o)
`endif
    );

    all_gates #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(1'b0), .b(1'b0), .in_valid(s_valid), .clr(1'b0),
        .and_out(s_and), .or_out(s_or), .not_out(s_not), .nand_out(s_nand),
        .nor_out(s_nor), .xor_out(s_xor), .xnor_out(s_xnor), .out_valid(s_ov),
        .sample_cnt(s_cnt), .combo_seen(s_combo)
`ifdef ALL_GATES_PARITY_EN
        , .parity_out(s_par)
`endif
    );

`ifdef ALL_GATES_PARITY_EN
    all_gates #(.WIDTH(4), .CNT_W(16)) u_par (
        .clk(clk), .rst_n(rst_n), .a(pa), .b(pb), .in_valid(p_valid), .clr(1'b0),
        .and_out(p_and), .or_out(p_or), .not_out(p_not), .nand_out(p_nand),
        .nor_out(p_nor), .xor_out(p_xor), .xnor_out(p_xnor), .out_valid(p_ov),
        .sample_cnt(p_cnt), .combo_seen(p_combo), .parity_out(p_par)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] gates();
        return {and_o, or_o, not_o, nand_o, nor_o, xor_o, xnor_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {and,or,not,nand,nor,xor,xnor} for (a,b) = 00,01,10,11
    logic [6:0] exp_tab [4] = '{7'b0011101, 7'b0111010, 7'b0101010, 7'b1100001};

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0; in_valid = 1'b0; clr = 1'b0; s_valid = 1'b0;
`ifdef ALL_GATES_PARITY_EN
        pa = 4'h0; pb = 4'h0; p_valid = 1'b0;
`endif
        #12;
        check("rst_gates", {25'd0, gates()}, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'h0);
        check("rst_cnt", {16'd0, sample_cnt}, 32'h0);
        check("rst_combo", {28'd0, combo_seen}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Truth table, one pair per cycle
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = i[1:0];
            a = ab[1]; b = ab[0]; in_valid = 1'b1;
            tick();
            check($sformatf("tt_gates_%0d", i), {25'd0, gates()}, {25'd0, exp_tab[i]});
            check($sformatf("tt_valid_%0d", i), {31'd0, out_valid}, 32'h1);
`ifdef ALL_GATES_PARITY_EN
            check($sformatf("tt_par_%0d", i), {31'd0, par_o}, {31'd0, ab[1]});
`endif
        end
        in_valid = 1'b0;
        check("cnt4", {16'd0, sample_cnt}, 32'd4);
        check("combo_all", {28'd0, combo_seen}, 32'hF);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt", {16'd0, sample_cnt}, 32'd0);
        check("clr_combo", {28'd0, combo_seen}, 32'h0);
        check("clr_novalid", {31'd0, out_valid}, 32'h0);

        // clr together with a sample: gates still load, counter/coverage stay clear
        clr = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b0;
        tick();
        clr = 1'b0;
        check("clrv_gates", {25'd0, gates()}, {25'd0, 7'b0101010});
        check("clrv_valid", {31'd0, out_valid}, 32'h1);
        check("clrv_cnt", {16'd0, sample_cnt}, 32'd0);
        check("clrv_combo", {28'd0, combo_seen}, 32'h0);

        // Load 11 then hold with inputs changed
        a = 1'b1; b = 1'b1; in_valid = 1'b1;
        tick();
        check("ld11_gates", {25'd0, gates()}, {25'd0, 7'b1100001});
        check("ld11_cnt", {16'd0, sample_cnt}, 32'd1);
        check("ld11_combo", {28'd0, combo_seen}, 32'h8);
        a = 1'b0; b = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_gates_%0d", i), {25'd0, gates()}, {25'd0, 7'b1100001});
            check($sformatf("hold_valid_%0d", i), {31'd0, out_valid}, 32'h0);
        end
        check("hold_cnt", {16'd0, sample_cnt}, 32'd1);

        // Asynchronous reset between edges discards the in-flight result
        a = 1'b1; b = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gates", {25'd0, gates()}, 32'h0);
        check("arst_valid", {31'd0, out_valid}, 32'h0);
        check("arst_cnt", {16'd0, sample_cnt}, 32'h0);
        check("arst_combo", {28'd0, combo_seen}, 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", {31'd0, out_valid}, 32'h0);
        check("post_rst_gates", {25'd0, gates()}, 32'h0);

        // Saturating 2-bit counter
        s_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("sat_%0d", i), {30'd0, s_cnt}, (i > 3) ? 32'd3 : i);
        end
        s_valid = 1'b0;
        tick();
        check("sat_hold", {30'd0, s_cnt}, 32'd3);

`ifdef ALL_GATES_PARITY_EN
        pa = 4'hA; pb = 4'h6; p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        check("p4_xor", {28'd0, p_xor}, 32'hC);
        check("p4_nand", {28'd0, p_nand}, 32'hD);
        check("p4_parity", {31'd0, p_par}, 32'h0);
        pa = 4'h7; pb = 4'h0; p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        check("p4_parity_odd", {31'd0, p_par}, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
